updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count register width in bits, legal range 1..32.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal count, so the modulus is MAX+1; legal range 1..2**WIDTH-1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port CE, input, 1 bit: count enable.
REQ-006 SHALL have port UP, input, 1 bit: direction (1 = increment, 0 = decrement).
REQ-007 SHALL have port LD, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port D, input, WIDTH bits: load value.
REQ-009 SHALL have port O, output, WIDTH bits: current count, registered.
REQ-010 SHALL have port cout, output, 1 bit: terminal-count carry/borrow, combinational.

Function
REQ-011 SHALL hold O in the range 0..MAX at all times after the first reset.
REQ-012 SHALL apply per-edge priority RESET > LD > CE; with none of these asserted, O holds.
REQ-013 SHALL, on LD=1, load O <= D when D <= MAX and O <= MAX when D > MAX; CE and UP are ignored that cycle.
REQ-014 SHALL, on CE=1 with UP=1, set O <= O+1 when O < MAX and O <= 0 when O == MAX (wrap).
REQ-015 SHALL, on CE=1 with UP=0, set O <= O-1 when O > 0 and O <= MAX when O == 0 (wrap).
REQ-016 SHALL drive cout = CE & ~LD & ~RESET & ((UP & O==MAX) | (~UP & O==0)), in the same cycle as the wrapping edge it predicts.
REQ-017 SHALL change O at most once per CLK edge; one count step has a latency of one cycle.
REQ-018 SHALL switch direction on any cycle, UP being sampled per edge, with no dead cycle.
REQ-019 SHALL, with MAX = 2**WIDTH-1, behave as a plain binary modulo-2**WIDTH counter; in up mode cout is then identical to the adder carry-out.
REQ-020 SHALL produce no X on O or cout after the first reset edge for any input sequence without X.

Reset
REQ-021 SHALL set O <= 0 on any rising CLK edge with RESET=1, regardless of LD and CE.
REQ-022 SHALL hold cout at 0 while RESET=1.
REQ-023 SHALL abandon any count or load in progress when RESET is asserted; counting resumes from 0 on the first edge after deassertion.

Configuration
REQ-024 SHALL support the macro UPDOWN_MOD_COUNTER_SATURATE_EN.
REQ-025 SHALL, when UPDOWN_MOD_COUNTER_SATURATE_EN is defined, replace wrap with saturation: up at MAX holds MAX, down at 0 holds 0; cout keeps the REQ-016 definition and flags the attempted overflow.
REQ-026 SHALL, when the macro is undefined, wrap per REQ-014/REQ-015; no other behaviour differs.

Structure
REQ-027 SHALL take from shared package counter_pkg: constant COUNTER_DEFAULT_WIDTH = 4, a direction typedef (DIR_DOWN = 0, DIR_UP = 1) and a terminal-count helper function.
REQ-028 SHALL place the next-value arithmetic in one sub-module, counter_incdec (inputs: count, UP, MAX; outputs: next value, terminal flag); the top level holds the register and the priority mux.
REQ-029 SHALL check parameter legality (REQ-001, REQ-002) at elaboration and fail elaboration on violation.

Verification
REQ-030 SHALL cover: WIDTH=4, MAX=15, reset then CE=1, UP=1 for 17 cycles -> O runs 0..15, 0, 1; cout=1 only in the cycle O=15.
REQ-031 SHALL cover: WIDTH=4, MAX=9, UP=0 from reset -> O runs 0, 9, 8 ... 0, 9; cout=1 in each cycle O=0.
REQ-032 SHALL cover: WIDTH=4, MAX=9, LD=1 with D=12 and CE=1 on the same edge -> O=9 next cycle, no count applied; then LD=1 with D=3 -> O=3.
REQ-033 SHALL cover: RESET=1 together with LD=1 and CE=1 while O=7 -> O=0 next cycle, cout=0 throughout reset.
REQ-034 SHALL cover: with UPDOWN_MOD_COUNTER_SATURATE_EN, MAX=9, O=9, UP=1, CE=1 for 3 cycles -> O stays 9, cout=1; then UP=0 -> O=8.
REQ-035 SHALL cover: alternate UP each cycle from O=5 with CE=1 -> O runs 6, 5, 6, 5 with no dead cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared counter definitions: default width, count direction and
// the terminal-count helper used by the next-value logic.
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic at_terminal(
    input dir_e        dir,
    input logic [31:0] count,
    input logic [31:0] max
  );
    return (dir == DIR_UP) ? (count == max) : (count == 32'd0);
  endfunction

endpackage

// File: rtl/counter_incdec.sv
// Next-value arithmetic for the modulo up/down counter.
// Optional macro UPDOWN_MOD_COUNTER_SATURATE_EN: saturate instead of wrap.
module counter_incdec
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  dir_e             up,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] next_count,
  output logic             term
);

  assign term = at_terminal(up, 32'(count), 32'(max));

  always_comb begin
    next_count = count;
    if (term) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
      next_count = count;
`else
      next_count = (up == DIR_UP) ? '0 : max;
`endif
    end else if (up == DIR_UP) begin
      next_count = count + WIDTH'(1);
    end else begin
      next_count = count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous load and reset.
// Optional macro UPDOWN_MOD_COUNTER_SATURATE_EN: saturate instead of wrap.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int                WIDTH = COUNTER_DEFAULT_WIDTH,
  parameter longint unsigned   MAX   = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             cout
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "updown_mod_counter: WIDTH must be 1..32");
  end

  if (MAX < 64'd1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "updown_mod_counter: MAX must be 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] next_count;
  logic             term;
  dir_e             dir;

  assign dir = dir_e'(UP);

  counter_incdec #(
    .WIDTH(WIDTH)
  ) u_incdec (
    .count      (O),
    .up         (dir),
    .max        (MAX_V),
    .next_count (next_count),
    .term       (term)
  );

  // Carry predicts the wrapping edge; load and reset suppress it.
  assign cout = CE & ~LD & ~RESET & term;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      O <= '0;
    end else if (LD) begin
      O <= (D > MAX_V) ? MAX_V : D;
    end else if (CE) begin
      O <= next_count;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: the driver queues the expected O/cout per cycle,
// the monitor pops and compares on the falling edge.
module tb_updown_mod_counter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CE = 1'b0;
  logic       UP = 1'b0;
  logic       LD = 1'b0;
  logic [3:0] D = 4'd0;
  logic [3:0] o15, o9;
  logic       c15, c9;

  updown_mod_counter #(.WIDTH(4), .MAX(15)) dut15 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .UP(UP),
    .LD(LD), .D(D), .O(o15), .cout(c15)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(9)) dut9 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .UP(UP),
    .LD(LD), .D(D), .O(o9), .cout(c9)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         sel;
    logic [3:0] o;
    logic       c;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0] ao;
      logic       ac;
      e  = q.pop_front();
      ao = (e.sel == 15) ? o15 : o9;
      ac = (e.sel == 15) ? c15 : c9;
      checks++;
      if (ao !== e.o || ac !== e.c) begin
        failures++;
        $display("FAIL %s: got O=%0d cout=%b, want O=%0d cout=%b",
                 e.tag, ao, ac, e.o, e.c);
      end
    end
  end

  // One cycle: drive inputs, queue what this cycle must show, take the edge.
  task automatic step(
    input logic       rst, ld, ce, up,
    input logic [3:0] d,
    input int         sel,
    input logic [3:0] eo,
    input logic       ec,
    input string      tag
  );
    exp_t e;
    RESET = rst; LD = ld; CE = ce; UP = up; D = d;
    if (sel != 0) begin
      e.sel = sel; e.o = eo; e.c = ec; e.tag = tag;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    step(1, 0, 1, 1, 0, 0, 0, 0, "init");
    step(1, 1, 1, 1, 5, 15, 0, 0, "reset_state15");
    step(1, 0, 1, 0, 0, 9, 0, 0, "reset_state9");

    // Up count modulo 16, 17 cycles from reset.
    for (int k = 0; k < 17; k++)
      step(0, 0, 1, 1, 0, 15, 4'(k % 16), (k == 15), "up16");

    // Down count modulo 10 from reset.
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst");
    for (int k = 0; k < 12; k++) begin
      logic [3:0] eo;
      eo = (k == 0) ? 4'd0 : (k <= 10) ? 4'(10 - k) : 4'd9;
      step(0, 0, 1, 0, 0, 9, eo, (eo == 0), "down10");
    end

    // Load beats count; out-of-range load clamps to MAX.
    step(0, 1, 1, 1, 12, 9, 8, 0, "ld_clamp_cyc");
    step(0, 0, 0, 1, 0, 9, 9, 0, "ld_clamp");
    step(0, 1, 1, 0, 3, 9, 9, 0, "ld3_cyc");
    step(0, 0, 0, 0, 0, 9, 3, 0, "ld3");
    step(0, 0, 0, 1, 0, 9, 3, 0, "hold");

    // Reset beats load and count.
    step(0, 1, 0, 0, 7, 0, 0, 0, "ld7");
    step(1, 1, 1, 1, 5, 15, 7, 0, "rst_ld_ce");
    step(1, 0, 1, 0, 0, 15, 0, 0, "rst_cout0");
    step(0, 0, 1, 1, 0, 15, 0, 0, "resume");
    step(0, 0, 0, 1, 0, 15, 1, 0, "resume1");

    // Terminal behaviour at MAX=9: wrap or saturate.
    step(0, 1, 0, 0, 9, 0, 0, 0, "ld9");
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
    step(0, 0, 1, 1, 0, 9, 9, 1, "sat0");
    step(0, 0, 1, 1, 0, 9, 9, 1, "sat1");
    step(0, 0, 1, 1, 0, 9, 9, 1, "sat2");
    step(0, 0, 1, 0, 0, 9, 9, 0, "sat_down");
    step(0, 0, 0, 0, 0, 9, 8, 0, "sat_after");
`else
    step(0, 0, 1, 1, 0, 9, 9, 1, "wrap0");
    step(0, 0, 1, 1, 0, 9, 0, 0, "wrap1");
    step(0, 0, 1, 1, 0, 9, 1, 0, "wrap2");
    step(0, 0, 1, 0, 0, 9, 2, 0, "wrap_down");
    step(0, 0, 0, 0, 0, 9, 1, 0, "wrap_after");
`endif

    // Direction toggles every cycle from 5.
    step(0, 1, 0, 0, 5, 0, 0, 0, "ld5");
    step(0, 0, 1, 1, 0, 15, 5, 0, "alt0");
    step(0, 0, 1, 0, 0, 15, 6, 0, "alt1");
    step(0, 0, 1, 1, 0, 15, 5, 0, "alt2");
    step(0, 0, 1, 0, 0, 15, 6, 0, "alt3");
    step(0, 0, 0, 0, 0, 15, 5, 0, "alt4");

    // Down wrap at full modulus.
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst2");
    step(0, 0, 1, 0, 0, 15, 0, 1, "dwrap16");
    step(0, 0, 0, 0, 0, 15, 15, 0, "dwrap16b");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge CLK);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
